// File: rtl/alut_age_checker13.sv
// LUT aging sweep: reads every entry, evicts valid entries older than age_thresh13.
// Optional eviction statistics enabled by defining ALUT_AGE_STATS_EN.
module alut_age_checker13 #(
  parameter int DW = 83,
  parameter int DD = 256
) (
  input  logic          pclk13,
  input  logic          n_p_reset13,
  input  logic          start_sweep13,
  input  logic [31:0]   curr_time13,
  input  logic [31:0]   age_thresh13,
  input  logic          add_busy13,
  input  logic [DW-1:0] mem_read_data_age13,
  output logic [7:0]    mem_addr_age13,
  output logic          mem_write_age13,
  output logic [DW-1:0] mem_write_data_age13,
  output logic          sweep_busy13,
  output logic          sweep_done13,
  output logic [8:0]    age_evict_cnt13
);

  localparam int VLD_BIT = 82;
  localparam int TS_HI   = 81;
  localparam int TS_LO   = 50;
  localparam logic [7:0]    LAST_IDX   = 8'(DD - 1);
  localparam logic [DW-1:0] VALID_MASK = {{(DW-1){1'b0}}, 1'b1} << VLD_BIT;

  typedef enum logic [2:0] {IDLE, RD, CHK, WR, NXT} state_t;

  state_t        state_q, state_d;
  logic [7:0]    index_q, index_d;
  logic [DW-1:0] entry_q, entry_d;
  logic          done_q, done_d;
  logic [31:0]   age;
  logic          write_fire;
  logic          sweep_start;

  // Modulo-2^32 subtraction keeps the age correct across timer wrap-around.
  assign age         = curr_time13 - mem_read_data_age13[TS_HI:TS_LO];
  assign write_fire  = (state_q == WR) && !add_busy13;
  assign sweep_start = (state_q == IDLE) && start_sweep13;

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    entry_d = entry_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_sweep13) begin
          index_d = 8'd0;
          state_d = RD;
        end
      end
      RD: begin
        if (!add_busy13) state_d = CHK;
      end
      CHK: begin
        entry_d = mem_read_data_age13;
        if (mem_read_data_age13[VLD_BIT] && (age > age_thresh13)) state_d = WR;
        else                                                      state_d = NXT;
      end
      // A stalled write goes back to RD so the entry is re-read before it is overwritten.
      WR: begin
        if (add_busy13) state_d = RD;
        else            state_d = NXT;
      end
      NXT: begin
        if (index_q == LAST_IDX) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          index_d = index_q + 8'd1;
          state_d = RD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk13 or negedge n_p_reset13) begin
    if (!n_p_reset13) begin
      state_q <= IDLE;
      index_q <= 8'd0;
      entry_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      entry_q <= entry_d;
      done_q  <= done_d;
    end
  end

  assign mem_addr_age13       = index_q;
  assign mem_write_age13      = write_fire;
  assign mem_write_data_age13 = (state_q == WR) ? (entry_q & ~VALID_MASK) : '0;
  assign sweep_busy13         = (state_q != IDLE);
  assign sweep_done13         = done_q;

`ifdef ALUT_AGE_STATS_EN
  logic [8:0] evict_cnt_q, evict_cnt_d;

  always_comb begin
    evict_cnt_d = evict_cnt_q;
    if (sweep_start)     evict_cnt_d = 9'd0;
    else if (write_fire) evict_cnt_d = evict_cnt_q + 9'd1;
  end

  always_ff @(posedge pclk13 or negedge n_p_reset13) begin
    if (!n_p_reset13) evict_cnt_q <= 9'd0;
    else              evict_cnt_q <= evict_cnt_d;
  end

  assign age_evict_cnt13 = evict_cnt_q;
`else
  logic unused_start;
  assign unused_start    = sweep_start;
  assign age_evict_cnt13 = 9'd0;
`endif

endmodule

// File: tb/tb_alut_age_checker13.sv
// Self-checking bench for alut_age_checker13: LUT memory model plus a sweep-level eviction model.
module tb_alut_age_checker13;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] curr;
  logic [31:0] thresh;
  logic        busy_in;
  logic [82:0] rd_data;
  logic [7:0]  addr;
  logic        wr_en;
  logic [82:0] wr_data;
  logic        busy;
  logic        done;
  logic [8:0]  cnt;

  localparam logic [82:0] VMASK = {1'b1, 82'd0};

  typedef struct packed {
    logic [7:0]  a;
    logic [82:0] d;
  } wr_t;

  logic [82:0] mem [256];
  logic        host_we;
  logic [7:0]  host_addr;
  logic [82:0] host_data;
  wr_t         exp_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          wr_seen = 0;
  logic [7:0]  prev_addr = 8'd0;

  alut_age_checker13 dut (
    .pclk13               (clk),
    .n_p_reset13          (rst_n),
    .start_sweep13        (start),
    .curr_time13          (curr),
    .age_thresh13         (thresh),
    .add_busy13           (busy_in),
    .mem_read_data_age13  (rd_data),
    .mem_addr_age13       (addr),
    .mem_write_age13      (wr_en),
    .mem_write_data_age13 (wr_data),
    .sweep_busy13         (busy),
    .sweep_done13         (done),
    .age_evict_cnt13      (cnt)
  );

  always #5 clk = ~clk;

  // Synchronous-read LUT; the DUT write port has priority over the bench's host port.
  always @(posedge clk) begin
    if (wr_en)        mem[addr] <= wr_data;
    else if (host_we) mem[host_addr] <= host_data;
    rd_data <= mem[addr];
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic evicts(input logic [82:0] e, input logic [31:0] c, input logic [31:0] t);
    logic [31:0] a;
    a = c - e[81:50];
    return e[82] && (a > t);
  endfunction

  function automatic logic [82:0] mkEntry(input logic v, input logic [31:0] ts);
    return {v, ts, 2'($urandom), 32'($urandom), 16'($urandom)};
  endfunction

  task automatic hostWrite(input logic [7:0] a, input logic [82:0] d);
    host_addr = a;
    host_data = d;
    host_we   = 1'b1;
    @(posedge clk); #1;
    host_we   = 1'b0;
  endtask

  task automatic fillInvalid();
    for (int i = 0; i < 256; i++) hostWrite(8'(i), mkEntry(1'b0, $urandom));
  endtask

  task automatic fillRandom(input logic [31:0] c, input logic [31:0] t);
    logic [31:0] a;
    for (int i = 0; i < 256; i++) begin
      case ($urandom % 5)
        0:       a = t;
        1:       a = t + 32'd1;
        2:       a = t - 32'd1;
        3:       a = 32'd0;
        default: a = $urandom;
      endcase
      hostWrite(8'(i), mkEntry(($urandom % 4) != 0, c - a));
    end
  endtask

  // Checks every output cycle: writes match the predicted eviction list, quiet outputs when idle.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (wr_en === 1'b1) begin
        wr_seen++;
        checkOutput("wr_while_add_busy", busy_in, 0);
        checkOutput("write_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          checkOutput("wr_addr", addr, exp_q[0].a);
          checkOutput("wr_data", wr_data, exp_q[0].d);
          void'(exp_q.pop_front());
        end
      end
      if (busy !== 1'b1) begin
        checkOutput("idle_wr_en", wr_en, 0);
        checkOutput("idle_wr_data", wr_data, 0);
        prev_addr = 8'd0;
      end else begin
        checkOutput("addr_monotonic", addr >= prev_addr, 1);
        prev_addr = addr;
      end
    end
  end

  // Runs one sweep: stall_mode 0 none, 1 random stalls plus an ignored start, 2 directed WR stall at index 9.
  task automatic applyStimulus(input logic [31:0] c, input logic [31:0] t, input int stall_mode, input int exp_cycles);
    int          cyc;
    int          n_exp;
    int          bad;
    logic [82:0] fin [256];
    logic [82:0] fresh;
    curr   = c;
    thresh = t;
    exp_q.delete();
    n_exp  = 0;
    for (int i = 0; i < 256; i++) begin
      fin[i] = mem[i];
      if (evicts(mem[i], c, t)) begin
        exp_q.push_back({8'(i), mem[i] & ~VMASK});
        fin[i] = mem[i] & ~VMASK;
        n_exp++;
      end
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc   = 0;
    checkOutput("busy_after_start", busy, 1);
    checkOutput("first_addr", addr, 0);
    while (done !== 1'b1 && cyc < 5000) begin
      if (stall_mode == 1) begin
        busy_in = (($urandom % 5) == 0);
        start   = (cyc == 100);
      end else if (stall_mode == 2) begin
        if (cyc >= 29 && cyc <= 34) checkOutput("stall_addr", addr, 9);
        if (cyc == 29) begin
          fresh     = mkEntry(1'b1, 32'd5);
          busy_in   = 1'b1;
          host_addr = 8'd9;
          host_data = fresh;
          host_we   = 1'b1;
          fin[9]    = fresh & ~VMASK;
          if (exp_q.size() > 0) exp_q[0] = {8'd9, fresh & ~VMASK};
        end
        if (cyc == 30) host_we = 1'b0;
        if (cyc == 34) busy_in = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    busy_in = 1'b0;
    start   = 1'b0;
    host_we = 1'b0;
    checkOutput("sweep_done_seen", done, 1);
    if (exp_cycles > 0) checkOutput("done_latency", cyc, exp_cycles);
    checkOutput("busy_at_done", busy, 0);
    checkOutput("writes_left", exp_q.size(), 0);
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== fin[i]) bad++;
    checkOutput("final_lut", bad, 0);
`ifdef ALUT_AGE_STATS_EN
    checkOutput("evict_cnt", cnt, n_exp);
`else
    checkOutput("evict_cnt", cnt, 0);
`endif
    @(posedge clk); #1;
    checkOutput("done_one_cycle", done, 0);
`ifdef ALUT_AGE_STATS_EN
    checkOutput("evict_cnt_hold", cnt, n_exp);
`else
    checkOutput("evict_cnt_hold", cnt, 0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          w0;
    int          cyc;
    logic [82:0] e;
    logic [31:0] c;
    logic [31:0] t;
    rst_n     = 1'b0;
    start     = 1'b0;
    curr      = 32'd0;
    thresh    = 32'd0;
    busy_in   = 1'b0;
    host_we   = 1'b0;
    host_addr = 8'd0;
    host_data = '0;
    #2;
    checkOutput("rst_addr", addr, 0);
    checkOutput("rst_wr_en", wr_en, 0);
    checkOutput("rst_wr_data", wr_data, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_cnt", cnt, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] all entries invalid");
    fillInvalid();
    w0 = wr_seen;
    applyStimulus(32'h1234, 32'h10, 0, 768);
    checkOutput("invalid_writes", wr_seen - w0, 0);

    $display("[TB] entry 5 aged out");
    fillInvalid();
    e = mkEntry(1'b1, 32'd100);
    hostWrite(8'd5, e);
    w0 = wr_seen;
    applyStimulus(32'd300, 32'd150, 0, 769);
    checkOutput("e5_writes", wr_seen - w0, 1);
    checkOutput("e5_valid", mem[5][82], 0);
    checkOutput("e5_body", mem[5][81:0], e[81:0]);

    $display("[TB] wrap-around age equal to threshold");
    fillInvalid();
    e = mkEntry(1'b1, 32'hFFFF_FFF0);
    hostWrite(8'd7, e);
    w0 = wr_seen;
    applyStimulus(32'h10, 32'h20, 0, 768);
    checkOutput("e7_keep_writes", wr_seen - w0, 0);
    checkOutput("e7_keep_valid", mem[7][82], 1);
    w0 = wr_seen;
    applyStimulus(32'h10, 32'h1F, 0, 769);
    checkOutput("e7_evict_writes", wr_seen - w0, 1);
    checkOutput("e7_evict_valid", mem[7][82], 0);

    $display("[TB] add_busy stall in WR at index 9");
    fillInvalid();
    hostWrite(8'd9, mkEntry(1'b1, 32'd0));
    w0 = wr_seen;
    applyStimulus(32'd1000, 32'd10, 2, 776);
    checkOutput("e9_writes", wr_seen - w0, 1);

    $display("[TB] reset mid-sweep at index 40");
    fillInvalid();
    hostWrite(8'd40, mkEntry(1'b1, 32'd0));
    curr   = 32'd1000;
    thresh = 32'd10;
    exp_q.delete();
    w0     = wr_seen;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    cyc    = 0;
    while (cyc < 122) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("addr_at_40", addr, 40);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_addr", addr, 0);
    checkOutput("mid_rst_wr_en", wr_en, 0);
    checkOutput("mid_rst_wr_data", wr_data, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_done", done, 0);
    checkOutput("mid_rst_cnt", cnt, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    checkOutput("mid_rst_writes", wr_seen - w0, 0);
    checkOutput("e40_intact", mem[40][82], 1);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("no_autostart", busy, 0);
    applyStimulus(32'd1000, 32'd10, 0, 769);
    checkOutput("e40_after_restart", wr_seen - w0, 1);

    $display("[TB] randomized sweeps with stalls");
    for (int k = 0; k < 6; k++) begin
      c = $urandom;
      t = (k % 2 == 0) ? 32'($urandom_range(0, 5000)) : $urandom;
      fillRandom(c, t);
      applyStimulus(c, t, 1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
